// File: rtl/servo_hle_gen.sv
`default_nettype none
// ============================================================================
// Module   : servo_hle_gen
// Purpose  : High-level emulation of the CD servo microcontroller on the
//            slave-processor byte link. Decodes host command bytes, queues
//            ACK/STATUS response frames in a FIFO, models timed tray motion,
//            reports disc changes unsolicited and paces the host with a
//            mode-fault kick pulse.
// Ports    : clk, reset            clock, synchronous active-high reset
//            spi_write/spi_mosi    host byte strobe and byte
//            spi_miso              combinational reply byte (FF when idle)
//            mode_fault            one-cycle kick pulse to the host SPI
//            audio_cd, img_mount,
//            img_mounted           CD image mount status from image logic
//            tray_open             tray fully open
//            disc_code             02 CD-i, 01 audio, 03 none
//            overflow              sticky, a frame was dropped for lack of room
// Revision : 1.0 - initial release
// ============================================================================
module servo_hle_gen #(
  parameter int RESP_DEPTH = 8,
  parameter int BYTE_GAP   = 80,
  parameter int FRAME_GAP  = 767,
  parameter int TRAY_TICKS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_write,
  input  logic [7:0] spi_mosi,
  output logic [7:0] spi_miso,
  output logic       mode_fault,
  input  logic       audio_cd,
  input  logic       img_mount,
  input  logic       img_mounted,
  output logic       tray_open,
  output logic [7:0] disc_code,
  output logic       overflow
);

  localparam int AW       = $clog2(RESP_DEPTH);
  localparam int KICK_MAX = (FRAME_GAP > BYTE_GAP) ? FRAME_GAP : BYTE_GAP;
  localparam int KW       = $clog2(KICK_MAX + 1);
  localparam int TW       = $clog2(TRAY_TICKS + 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(RESP_DEPTH);

  typedef enum logic [1:0] {GEN_IDLE, GEN_WRITE, GEN_GAP} gen_state_t;
  typedef enum logic [1:0] {TRAY_CLOSED, TRAY_MOVING_OPEN, TRAY_OPEN, TRAY_MOVING_CLOSE} tray_state_t;

  // ---------------------------------------------------------------- FIFO
  // Each entry is {last, data}; pointers carry an extra wrap bit.
  logic [8:0]  fifo_mem [RESP_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, fill, free;
  logic        fifo_empty, pop, push, push_last;
  logic [7:0]  push_data;
  logic [8:0]  head;

  assign fill       = wr_ptr - rd_ptr;
  assign free       = DEPTH - fill;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign pop        = spi_write && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {push_last, push_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ------------------------------------------------------ command decode
  gen_state_t  gen_state, gen_state_next;
  logic        ack_req, stat_req;
  logic        gen_busy, decode_en, cmd_accept, cmd_open, cmd_close, cmd_status;

  // A pending request counts as busy so a new command cannot slip in
  // ahead of a frame that is about to be written.
  assign gen_busy   = (gen_state != GEN_IDLE) || ack_req || stat_req;
  assign decode_en  = spi_write && fifo_empty && !gen_busy;
  assign cmd_status = decode_en && (spi_mosi == 8'hB0);
  assign cmd_open   = decode_en && (spi_mosi == 8'hA6);
  assign cmd_close  = decode_en && (spi_mosi == 8'hA7);
  assign cmd_accept = cmd_status || cmd_open || cmd_close;

  always_comb begin
    spi_miso = 8'hFF;
    if (spi_write) begin
      if (!fifo_empty)     spi_miso = head[7:0];
      else if (cmd_accept) spi_miso = 8'h55;
      else if (decode_en && spi_mosi == 8'hDD) spi_miso = 8'hEE;
    end
  end

  // ------------------------------------------------------------- tray FSM
  tray_state_t   tray_state, tray_next;
  logic [TW-1:0] tray_cnt, tray_cnt_next;
  logic          done_open, done_close;
  logic [7:0]    disc_reg, mounted_code, tray_code;

  assign mounted_code = img_mounted ? (audio_cd ? 8'h01 : 8'h02) : 8'h03;
  assign tray_open    = (tray_state == TRAY_OPEN);
  assign disc_code    = disc_reg;

  always_comb begin
    tray_next     = tray_state;
    tray_cnt_next = tray_cnt;
    done_open     = 1'b0;
    done_close    = 1'b0;
    tray_code     = 8'h23;
    unique case (tray_state)
      TRAY_CLOSED: begin
        tray_code = 8'h25;
        if (cmd_open) begin
          tray_next     = TRAY_MOVING_OPEN;
          tray_cnt_next = TW'(TRAY_TICKS);
        end
      end
      TRAY_MOVING_OPEN: begin
        if (cmd_close) begin
          tray_next     = TRAY_MOVING_CLOSE;
          tray_cnt_next = TW'(TRAY_TICKS);
        end else if (tray_cnt <= TW'(1)) begin
          // Finishing on the count of 1 lands the transition exactly
          // TRAY_TICKS edges after the move started.
          tray_next = TRAY_OPEN;
          done_open = 1'b1;
        end else begin
          tray_cnt_next = tray_cnt - TW'(1);
        end
      end
      TRAY_OPEN: begin
        tray_code = 8'h21;
        if (cmd_close) begin
          tray_next     = TRAY_MOVING_CLOSE;
          tray_cnt_next = TW'(TRAY_TICKS);
        end
      end
      TRAY_MOVING_CLOSE: begin
        if (cmd_open) begin
          tray_next     = TRAY_MOVING_OPEN;
          tray_cnt_next = TW'(TRAY_TICKS);
        end else if (tray_cnt <= TW'(1)) begin
          tray_next  = TRAY_CLOSED;
          done_close = 1'b1;
        end else begin
          tray_cnt_next = tray_cnt - TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tray_state <= TRAY_CLOSED;
      tray_cnt   <= '0;
      disc_reg   <= mounted_code;
    end else begin
      tray_state <= tray_next;
      tray_cnt   <= tray_cnt_next;
      if (img_mount)       disc_reg <= audio_cd ? 8'h01 : 8'h02;
      else if (done_open)  disc_reg <= 8'h03;
      else if (done_close) disc_reg <= mounted_code;
    end
  end

  // ------------------------------------------------------ frame generator
  logic       frame_stat, frame_stat_next, start_stat;
  logic [2:0] byte_idx, byte_idx_next;
  logic [7:0] snap_disc, snap_disc_next, snap_tray, snap_tray_next;
  logic       ack_clr, stat_clr, ovf_set, frame_done;
  logic [AW:0] frame_len;

  function automatic logic [7:0] frame_byte(input logic is_stat, input logic [2:0] idx,
                                            input logic [7:0] disc, input logic [7:0] tray);
    logic [7:0] b;
    b = 8'h01;
    if (!is_stat) begin
      if (idx == 3'd0) b = 8'h61;
    end else begin
      case (idx)
        3'd0:    b = 8'h03;
        3'd1:    b = 8'hB0;
        3'd2:    b = 8'h00;
        3'd3:    b = disc;
        default: b = tray;
      endcase
    end
    return b;
  endfunction

  assign start_stat = !ack_req;
  assign frame_len  = start_stat ? (AW + 1)'(5) : (AW + 1)'(3);
  assign frame_done = push && push_last;

  always_comb begin
    gen_state_next  = gen_state;
    frame_stat_next = frame_stat;
    byte_idx_next   = byte_idx;
    snap_disc_next  = snap_disc;
    snap_tray_next  = snap_tray;
    ack_clr         = 1'b0;
    stat_clr        = 1'b0;
    ovf_set         = 1'b0;
    push            = 1'b0;
    push_last       = 1'b0;
    push_data       = 8'h00;
    case (gen_state)
      GEN_IDLE: begin
        if (ack_req || stat_req) begin
          ack_clr  = ack_req;
          stat_clr = start_stat;
          if (free >= frame_len) begin
            push            = 1'b1;
            push_data       = frame_byte(start_stat, 3'd0, disc_reg, tray_code);
            frame_stat_next = start_stat;
            snap_disc_next  = disc_reg;
            snap_tray_next  = tray_code;
            byte_idx_next   = 3'd1;
            gen_state_next  = GEN_WRITE;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      GEN_WRITE: begin
        push      = 1'b1;
        push_data = frame_byte(frame_stat, byte_idx, snap_disc, snap_tray);
        push_last = (byte_idx == (frame_stat ? 3'd4 : 3'd2));
        if (push_last) gen_state_next = GEN_GAP;
        else           byte_idx_next  = byte_idx + 3'd1;
      end
      GEN_GAP:  gen_state_next = GEN_IDLE;
      default:  gen_state_next = GEN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gen_state  <= GEN_IDLE;
      frame_stat <= 1'b0;
      byte_idx   <= 3'd0;
      snap_disc  <= 8'h03;
      snap_tray  <= 8'h25;
      ack_req    <= 1'b0;
      stat_req   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      gen_state  <= gen_state_next;
      frame_stat <= frame_stat_next;
      byte_idx   <= byte_idx_next;
      snap_disc  <= snap_disc_next;
      snap_tray  <= snap_tray_next;
      // Sets win over clears so a request raised mid-frame stays pending.
      ack_req    <= (ack_req & ~ack_clr) | cmd_accept;
      stat_req   <= (stat_req & ~stat_clr) | cmd_status | img_mount | done_open | done_close;
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // --------------------------------------------------------- kick counter
  logic [KW-1:0] kick_cnt, kick_next;

  always_comb begin
    kick_next = kick_cnt;
    if (pop && head[8])                      kick_next = KW'(FRAME_GAP);
    else if (pop || cmd_accept)              kick_next = KW'(BYTE_GAP);
    else if (frame_done && kick_cnt == '0)   kick_next = KW'(BYTE_GAP);
    else if (kick_cnt != '0)                 kick_next = kick_cnt - KW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kick_cnt   <= '0;
      mode_fault <= 1'b0;
    end else begin
      kick_cnt   <= kick_next;
      mode_fault <= (kick_cnt == KW'(1));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_hle_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_hle_gen
// Purpose  : Self-checking bench for servo_hle_gen. A host-level model keeps
//            the expected response stream as a byte queue; every host write
//            pushes its expected reply to a scoreboard that a negedge monitor
//            compares against spi_miso.
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_hle_gen;
  localparam int RESP_DEPTH = 8;
  localparam int BYTE_GAP   = 80;
  localparam int FRAME_GAP  = 767;
  localparam int TRAY_TICKS = 4000;

  localparam int T_CLOSED = 0, T_MOV_OPEN = 1, T_OPEN = 2, T_MOV_CLOSE = 3;

  logic       clk = 1'b0;
  logic       reset, spi_write, mode_fault, audio_cd, img_mount, img_mounted;
  logic       tray_open, overflow;
  logic [7:0] spi_mosi, spi_miso, disc_code;

  always #5 clk = ~clk;

  servo_hle_gen #(
    .RESP_DEPTH(RESP_DEPTH), .BYTE_GAP(BYTE_GAP),
    .FRAME_GAP(FRAME_GAP), .TRAY_TICKS(TRAY_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .spi_write(spi_write), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .mode_fault(mode_fault), .audio_cd(audio_cd),
    .img_mount(img_mount), .img_mounted(img_mounted), .tray_open(tray_open),
    .disc_code(disc_code), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Host-level model: pending response bytes {last, data}, tray, disc.
  logic [8:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         m_tray, m_done;
  logic [7:0] m_disc;

  function automatic void check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic void check_range(string name, int got, int lo, int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, got, lo, hi, cyc);
    end
  endfunction

  function automatic logic [7:0] mounted_code();
    return img_mounted ? (audio_cd ? 8'h01 : 8'h02) : 8'h03;
  endfunction

  function automatic logic [7:0] tray_byte();
    if (m_tray == T_CLOSED) return 8'h25;
    if (m_tray == T_OPEN)   return 8'h21;
    return 8'h23;
  endfunction

  function automatic void model_push_frame(bit is_stat);
    logic [7:0] f[$];
    if (is_stat) begin
      f.push_back(8'h03); f.push_back(8'hB0); f.push_back(8'h00);
      f.push_back(m_disc); f.push_back(tray_byte());
    end else begin
      f.push_back(8'h61); f.push_back(8'h01); f.push_back(8'h01);
    end
    if (mq.size() + f.size() > RESP_DEPTH) return;  // dropped frame
    for (int i = 0; i < f.size(); i++) mq.push_back({(i == f.size() - 1), f[i]});
  endfunction

  function automatic void model_cmd(input logic [7:0] b, output logic [7:0] reply,
                                    output bit acc, output bit mv);
    acc = 1'b0; mv = 1'b0; reply = 8'hFF;
    if (b == 8'hDD) reply = 8'hEE;
    else if (b == 8'hB0 || b == 8'hA6 || b == 8'hA7) begin
      reply = 8'h55; acc = 1'b1;
      model_push_frame(1'b0);
      if (b == 8'hB0) model_push_frame(1'b1);
      if (b == 8'hA6 && (m_tray == T_CLOSED || m_tray == T_MOV_CLOSE)) begin
        m_tray = T_MOV_OPEN; mv = 1'b1;
      end
      if (b == 8'hA7 && (m_tray == T_OPEN || m_tray == T_MOV_OPEN)) begin
        m_tray = T_MOV_CLOSE; mv = 1'b1;
      end
    end
  endfunction

  // Scoreboard monitor: compare every host byte transfer mid-cycle.
  always @(negedge clk) begin
    if (!reset && spi_write) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spi_miso_unexpected: got %0h expected no transfer", spi_miso);
      end else begin
        mon_exp = exp_q.pop_front();
        check("spi_miso", spi_miso, mon_exp);
      end
    end
  end

  task automatic host_write(input logic [7:0] b, output bit acc, output bit was_last);
    logic [8:0] e;
    logic [7:0] reply;
    bit mv;
    acc = 1'b0; was_last = 1'b0; mv = 1'b0;
    if (mq.size() > 0) begin
      e = mq.pop_front(); reply = e[7:0]; was_last = e[8];
    end else begin
      model_cmd(b, reply, acc, mv);
    end
    exp_q.push_back(reply);
    @(posedge clk); #1; spi_write = 1'b1; spi_mosi = b;
    @(posedge clk); #1; spi_write = 1'b0; spi_mosi = 8'h00;
    if (mv) m_done = cyc + TRAY_TICKS;
  endtask

  task automatic wait_kick(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(posedge clk); #1; n++;
      if (mode_fault) return;
    end
    checks++; errors++;
    $display("FAIL kick_timeout: got no mode_fault expected one within %0d cycles", bound);
    n = -1;
  endtask

  task automatic quiet(input int ncyc);
    int pulses;
    pulses = 0;
    repeat (ncyc) begin @(posedge clk); #1; if (mode_fault) pulses++; end
    check("no_kick", pulses, 0);
  endtask

  task automatic drain();
    bit acc, lst;
    int n;
    while (mq.size() > 0) begin
      host_write(8'hAA, acc, lst);
      wait_kick(FRAME_GAP + 50, n);
      check("kick_gap", n, lst ? FRAME_GAP : BYTE_GAP);
    end
  endtask

  task automatic run_cmd(input logic [7:0] b);
    bit acc, lst;
    int n;
    host_write(b, acc, lst);
    if (acc) begin
      wait_kick(BYTE_GAP + 50, n);
      check("accept_gap", n, BYTE_GAP);
      drain();
    end else begin
      quiet(BYTE_GAP + 20);
    end
  endtask

  task automatic do_mount(input bit audio);
    int n;
    @(posedge clk); #1; audio_cd = audio; img_mounted = 1'b1; img_mount = 1'b1;
    @(posedge clk); #1; img_mount = 1'b0;
    m_disc = audio ? 8'h01 : 8'h02;
    model_push_frame(1'b1);
    wait_kick(BYTE_GAP + 50, n);
    check_range("mount_kick", n, BYTE_GAP + 1, BYTE_GAP + 8);
    drain();
    check("disc_code_mount", disc_code, m_disc);
  endtask

  task automatic tray_finish(input bit to_open);
    int n;
    if (cyc >= m_done - 1) begin
      checks++; errors++;
      $display("FAIL tray_sched: got cycle %0d expected before %0d", cyc, m_done - 1);
    end
    while (cyc < m_done - 1) begin @(posedge clk); #1; end
    if (to_open) begin
      check("tray_open_early", tray_open, 0);
      n = 0;
      while (!tray_open && n < 3) begin @(posedge clk); #1; n++; end
      check_range("tray_open_time", cyc - m_done, 0, 1);
    end
    m_tray = to_open ? T_OPEN : T_CLOSED;
    m_disc = to_open ? 8'h03 : mounted_code();
    model_push_frame(1'b1);
    wait_kick(BYTE_GAP + 50, n);
    check_range("tray_kick_time", cyc - m_done, BYTE_GAP + 1, BYTE_GAP + 9);
    drain();
    check("tray_open_final", tray_open, to_open);
    check("disc_code_tray", disc_code, m_disc);
  endtask

  task automatic do_reset();
    reset = 1'b1; spi_write = 1'b0; spi_mosi = 8'h00; img_mount = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    mq.delete(); exp_q.delete();
    m_tray = T_CLOSED; m_disc = mounted_code();
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc, lst;
    int n, sel;
    logic [7:0] other;
    reset = 1'b1; spi_write = 1'b0; spi_mosi = 8'h00;
    audio_cd = 1'b0; img_mount = 1'b0; img_mounted = 1'b0;
    do_reset();

    check("reset_miso", spi_miso, 8'hFF);
    check("reset_mode_fault", mode_fault, 0);
    check("reset_tray_open", tray_open, 0);
    check("reset_overflow", overflow, 0);
    check("reset_disc", disc_code, 8'h03);

    run_cmd(8'hDD);
    check("disc_after_dd", disc_code, 8'h03);
    do_mount(1'b0);
    run_cmd(8'hB0);

    for (int i = 0; i < 10; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: run_cmd(8'hDD);
        1: run_cmd(8'hB0);
        2: begin
          do other = 8'($urandom_range(0, 255));
          while (other == 8'hB0 || other == 8'hA6 || other == 8'hA7 || other == 8'hDD);
          run_cmd(other);
        end
        3: run_cmd(8'hA7);
        default: do_mount(1'($urandom_range(0, 1)));
      endcase
    end

    // Open, redundant open, then close/reverse/reverse with a mid-travel STATUS.
    run_cmd(8'hA6);
    tray_finish(1'b1);
    run_cmd(8'hA6);
    check("tray_open_redundant", tray_open, 1);
    run_cmd(8'hA7);
    run_cmd(8'hA6);
    run_cmd(8'hB0);
    run_cmd(8'hA7);
    tray_finish(1'b0);

    // Overflow: no reads while B0 fills the FIFO, then a mount STATUS.
    host_write(8'hB0, acc, lst);
    repeat (20) @(posedge clk);
    #1; audio_cd = 1'b1; img_mount = 1'b1;
    @(posedge clk); #1; img_mount = 1'b0;
    m_disc = 8'h01;
    model_push_frame(1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("overflow_set", overflow, 1);
    wait_kick(BYTE_GAP + 50, n);
    for (int k = 0; k < 4; k++) begin
      host_write(8'hAA, acc, lst);
      if (k < 3) begin
        wait_kick(FRAME_GAP + 50, n);
        check("ovf_kick_gap", n, lst ? FRAME_GAP : BYTE_GAP);
      end
    end
    check("overflow_sticky", overflow, 1);

    // Reset with bytes still queued.
    do_reset();
    check("rst2_overflow", overflow, 0);
    check("rst2_mode_fault", mode_fault, 0);
    check("rst2_tray_open", tray_open, 0);
    check("rst2_disc", disc_code, m_disc);
    quiet(BYTE_GAP + 20);
    run_cmd(8'hAA);
    run_cmd(8'hDD);
    run_cmd(8'hB0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
